// File: rtl/adsr_envelope_if.sv
// Signal bundle between the oscillator/control side and the ADSR envelope block.
interface adsr_envelope_if #(
  parameter int unsigned SAMPLE_W = 4,
  parameter int unsigned ENV_W    = 8
);
  logic                gate;
  logic [ENV_W-1:0]    attack_rate;
  logic [ENV_W-1:0]    decay_rate;
  logic [ENV_W-1:0]    sustain_level;
  logic [ENV_W-1:0]    release_rate;
  logic [SAMPLE_W-1:0] sample_in;
  logic [SAMPLE_W-1:0] amp_out;
  logic [ENV_W-1:0]    env_out;
  logic [2:0]          state_out;

  modport master (
    output gate, attack_rate, decay_rate, sustain_level, release_rate, sample_in,
    input  amp_out, env_out, state_out
  );

  modport slave (
    input  gate, attack_rate, decay_rate, sustain_level, release_rate, sample_in,
    output amp_out, env_out, state_out
  );
endinterface

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope: gate-driven 8-bit envelope stepped on a prescaled tick,
// scaling the oscillator sample into a registered output.
module adsr_envelope #(
  parameter int unsigned SAMPLE_W = 4,
  parameter int unsigned ENV_W    = 8,
  parameter int unsigned TICK_DIV = 16
) (
  input  logic             clk,
  input  logic             rst,
  adsr_envelope_if.slave   bus
);
  localparam int unsigned CNT_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PROD_W = SAMPLE_W + ENV_W;
  localparam logic [ENV_W-1:0] ENV_MAX = '1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t              state, state_n;
  logic [ENV_W-1:0]    env, env_n;
  logic [CNT_W-1:0]    prescale;
  logic                tick;
  logic                gate_q;
  logic                rise, fall;
  logic [ENV_W:0]      att_sum, dec_diff, rel_diff;
  logic [PROD_W-1:0]   prod;
  logic [SAMPLE_W-1:0] amp;

  assign tick = (prescale == CNT_W'(TICK_DIV - 1));
  assign rise = bus.gate & ~gate_q;
  assign fall = ~bus.gate & gate_q;

  // One extra bit so overflow/borrow is visible before saturating.
  assign att_sum  = {1'b0, env} + {1'b0, bus.attack_rate};
  assign dec_diff = {1'b0, env} - {1'b0, bus.decay_rate};
  assign rel_diff = {1'b0, env} - {1'b0, bus.release_rate};

  assign prod = PROD_W'(bus.sample_in) * PROD_W'(env);

  always_ff @(posedge clk) begin
    if (!rst) begin
      prescale <= '0;
      gate_q   <= 1'b0;
      state    <= IDLE;
      env      <= '0;
      amp      <= '0;
    end else begin
      prescale <= tick ? '0 : prescale + 1'b1;
      gate_q   <= bus.gate;
      state    <= state_n;
      env      <= env_n;
      amp      <= prod[PROD_W-1:ENV_W];
    end
  end

  always_comb begin
    state_n = state;
    env_n   = env;
    case (state)
      IDLE: begin
        if (rise) state_n = ATTACK;
      end
      ATTACK: begin
        if (fall) begin
          state_n = RELEASE;
        end else if (tick) begin
          env_n = att_sum[ENV_W] ? ENV_MAX : att_sum[ENV_W-1:0];
          if (env_n == ENV_MAX) state_n = DECAY;
        end
      end
      DECAY: begin
        // Entering at or below the sustain level settles immediately, tick or not.
        if (fall) begin
          state_n = RELEASE;
        end else if (env <= bus.sustain_level) begin
          env_n   = bus.sustain_level;
          state_n = SUSTAIN;
        end else if (tick) begin
          if (dec_diff[ENV_W] || (dec_diff[ENV_W-1:0] <= bus.sustain_level)) begin
            env_n   = bus.sustain_level;
            state_n = SUSTAIN;
          end else begin
            env_n = dec_diff[ENV_W-1:0];
          end
        end
      end
      SUSTAIN: begin
        if (fall) state_n = RELEASE;
        else      env_n   = bus.sustain_level;
      end
      RELEASE: begin
        if (rise) begin
          state_n = ATTACK;
        end else if (tick) begin
          if (rel_diff[ENV_W] || (rel_diff[ENV_W-1:0] == '0)) begin
            env_n   = '0;
            state_n = IDLE;
          end else begin
            env_n = rel_diff[ENV_W-1:0];
          end
        end
      end
      default: begin
        state_n = IDLE;
        env_n   = '0;
      end
    endcase
  end

  assign bus.env_out   = env;
  assign bus.state_out = state;
  assign bus.amp_out   = amp;
endmodule
